tilemap_reader: RTL
===================

Name: tilemap_reader

Overview:
- Read-side counterpart of the map-cell evaluator. The evaluator writes the 32x32 tile RAM at init; this block reads it.
- During display, it prefetches the tile byte for the next 16-pixel cell from RAM_sync, double-buffers it, and presents tile type, rotation and in-cell offsets to the tileMap ROM, aligned with the beam.
- It also serves a low-priority cell-query handshake so the pacman controller can read maze cells. Queries use the gaps between render fetches.

Parameters:
- FETCH_PHASE, 12: value of hpos[3:0] at which the next-cell fetch address is issued (legal range 3..13).
- LINE_FETCH_H, 784: hpos at which column 0 of the next line is fetched (in hblank).
- ADDR_W, 10: RAM address width, laid out as {row[4:0], col[4:0]}.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  high once map init is complete (driven from init/ready); low = block idle
- hpos  in  10  beam x from hvsync_generator
- vpos  in  10  beam y from hvsync_generator
- ram_addr  out  10  RAM_sync address, {row, col}
- ram_read  in  8  RAM_sync dout; registered read, valid 1 cycle after the address
- tile_type  out  2  current cell byte [1:0]
- rotation  out  2  current cell byte [3:2]
- xofs  out  3  hpos[3:1]
- yofs  out  3  vpos[3:1]
- query_req  in  1  controller request; held high until ack
- query_x  in  5  cell column; stable while req is high
- query_y  in  5  cell row; stable while req is high
- query_ack  out  1  one-cycle pulse
- query_data  out  8  cell byte; valid while query_ack is high

Behaviour:
- Reset (or enable low), synchronous:
  - Render FSM and query FSM go to IDLE.
  - ram_addr=0, cur_tile=0, next_tile=0, query_ack=0, query_data=0.
  - tile_type, rotation = 0. xofs/yofs still follow hpos/vpos combinationally.
- Render fetch, for the cell after current column c=hpos[8:4]:
  - Cycle T, where hpos[3:0]==FETCH_PHASE: drive ram_addr={vpos[8:4], (c+1) mod 32}. The column wraps 31->0 on the same row.
  - T+1: RAM registers the address.
  - T+2: latch ram_read into next_tile.
  - On the edge where hpos[3:0]==15, cur_tile <= next_tile, so cur_tile belongs to column hpos[8:4] for hpos[3:0]=0..15.
- Line fetch: at hpos==LINE_FETCH_H, drive ram_addr={(vpos+1)[8:4], 0}, using the same 2-cycle latch into next_tile. This gives column 0 correct data at hpos=0 of the next line.
- The render fetch window (the issue cycle and the following cycle) owns ram_addr. In all other cycles ram_addr is driven by the query FSM, or holds its last value.
- Query FSM states: IDLE -> ADDR -> WAIT -> ACK -> IDLE.
  - IDLE->ADDR only when query_req=1 and the cycles ADDR..ACK do not overlap a render window. Equivalently, the start is blocked when hpos[3:0] is in [FETCH_PHASE-2, FETCH_PHASE+1] or hpos is in [LINE_FETCH_H-2, LINE_FETCH_H+1].
  - ADDR: ram_addr={query_y, query_x}.
  - WAIT: RAM latency cycle.
  - ACK: query_data <= ram_read; query_ack=1 for exactly 1 cycle.
  - After ACK, IDLE for at least 1 cycle before accepting the next request, so a held req is not double-served.
  - Worst-case latency from req to ack: 8 cycles.
- Simultaneous events:
  - Render always has priority; a query never delays a render fetch.
  - If req rises while a start is blocked, the query waits in IDLE.
- enable falling mid-query: the query is abandoned with no ack, the FSM goes to IDLE, and the controller must re-request.
- enable rising: cur_tile stays 0 until the first swap completes after a full fetch.
- All arithmetic on row/col is modulo 32 (5-bit truncation).
- Nothing is gated by display_on; blanking is done at top level.

Decomposition:
- Shared package `pacman_pkg`:
  - FETCH_PHASE and LINE_FETCH_H defaults.
  - Cell-byte field positions (TYPE=[1:0], ROT=[3:2]).
  - Query FSM state encoding.
- One sub-module: `tile_query_fsm`. It holds the query FSM and window-blocking logic, and outputs its address plus a "want bus" flag to the top mux.

Test Plan:
1. Reset held 3 cycles with enable=1 -> query_ack=0, tile_type=0, rotation=0, ram_addr=0 on the cycle after reset.
2. RAM preloaded with cell(row2,col5)=8'h0B. Beam at vpos=32, hpos=76 (col4, phase 12) -> ram_addr=10'h045 that cycle; at hpos=80..95, tile_type=2'b11 and rotation=2'b10.
3. Column wrap: vpos=16, hpos=508 (col31, phase 12) -> ram_addr={5'd1, 5'd0}=10'h020.
4. Line fetch: cell(3,0)=8'h05, vpos=47, hpos=784 -> ram_addr=10'h060; at the next line (vpos=48), hpos=0..15 gives tile_type=1, rotation=1.
5. query_req with x=7, y=9, cell byte 8'h3C, issued at hpos[3:0]=2 -> ram_addr=10'h127 one cycle later; query_ack pulses 3 cycles after the start with query_data=8'h3C; the render fetch at phase 12 is unaffected.
6. query_req asserted at hpos[3:0]=11 -> no start until phase 14. Separately, drop enable in WAIT -> no ack, FSM returns to IDLE, ram_addr=0.

Source files
------------

// File: rtl/pacman_pkg.sv
// Shared definitions for the pacman maze datapath: beam timing defaults,
// cell-byte field layout and the cell-query FSM encoding.
package pacman_pkg;

  localparam int unsigned FETCH_PHASE_DEF  = 12;
  localparam int unsigned LINE_FETCH_H_DEF = 784;
  localparam int unsigned ADDR_W_DEF       = 10;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CELL_W  = 5;
  localparam int unsigned PHASE_W = 4;
  localparam int unsigned BYTE_W  = 8;

  localparam int unsigned TYPE_LSB = 0;
  localparam int unsigned ROT_LSB  = 2;
  localparam int unsigned FIELD_W  = 2;

  typedef struct packed {
    logic [FIELD_W-1:0] rot;
    logic [FIELD_W-1:0] ttype;
  } tile_attr_t;

  typedef enum logic [1:0] {
    Q_IDLE = 2'd0,
    Q_ADDR = 2'd1,
    Q_WAIT = 2'd2,
    Q_ACK  = 2'd3
  } qstate_e;

  // Extract render attributes from the low nibble of a cell byte.
  function automatic tile_attr_t cell_attr(input logic [3:0] cell_lo);
    tile_attr_t a;
    a.ttype = cell_lo[TYPE_LSB +: FIELD_W];
    a.rot   = cell_lo[ROT_LSB +: FIELD_W];
    return a;
  endfunction

endpackage

// File: rtl/tile_query_fsm.sv
// Low-priority maze-cell query engine; starts a RAM read only when the
// whole ADDR..ACK sequence stays clear of the render fetch windows.
module tile_query_fsm
  import pacman_pkg::*;
#(
  parameter int unsigned FETCH_PHASE  = FETCH_PHASE_DEF,
  parameter int unsigned LINE_FETCH_H = LINE_FETCH_H_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic [COORD_W-1:0] hpos_i,
  input  logic               req_i,
  input  logic [CELL_W-1:0]  x_i,
  input  logic [CELL_W-1:0]  y_i,
  input  logic [BYTE_W-1:0]  ram_read_i,
  output logic               want_bus_c_o,
  output logic [ADDR_W-1:0]  addr_c_o,
  output logic               ack_o,
  output logic [BYTE_W-1:0]  data_o
);

  qstate_e             state_q, state_d;
  logic                cool_q;
  logic [BYTE_W-1:0]   data_q;
  logic [PHASE_W-1:0]  phase_c;
  logic                blocked_c;

  always_comb begin
    phase_c   = hpos_i[PHASE_W-1:0];
    blocked_c = 1'b0;
    if ((phase_c >= PHASE_W'(FETCH_PHASE - 2)) && (phase_c <= PHASE_W'(FETCH_PHASE + 1)))
      blocked_c = 1'b1;
    if ((hpos_i >= COORD_W'(LINE_FETCH_H - 2)) && (hpos_i <= COORD_W'(LINE_FETCH_H + 1)))
      blocked_c = 1'b1;
  end

  // cool_q keeps the first IDLE cycle after ACK from re-serving a held request.
  always_comb begin
    state_d      = state_q;
    want_bus_c_o = 1'b0;
    case (state_q)
      Q_IDLE: begin
        if (req_i && !blocked_c && !cool_q) begin
          state_d      = Q_ADDR;
          want_bus_c_o = 1'b1;
        end
      end
      Q_ADDR:  state_d = Q_WAIT;
      Q_WAIT:  state_d = Q_ACK;
      Q_ACK:   state_d = Q_IDLE;
      default: state_d = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= Q_IDLE;
      cool_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cool_q  <= (state_q == Q_ACK);
      if (state_q == Q_WAIT) data_q <= ram_read_i;
    end
  end

  assign addr_c_o = ADDR_W'({y_i, x_i});
  assign ack_o    = (state_q == Q_ACK);
  assign data_o   = data_q;

endmodule

// File: rtl/tilemap_reader.sv
// Beam-aligned tile prefetch from the 32x32 maze RAM with double-buffered
// cell attributes, sharing the RAM port with a low-priority cell query.
module tilemap_reader
  import pacman_pkg::*;
#(
  parameter int unsigned FETCH_PHASE  = FETCH_PHASE_DEF,
  parameter int unsigned LINE_FETCH_H = LINE_FETCH_H_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COORD_W-1:0] hpos,
  input  logic [COORD_W-1:0] vpos,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [BYTE_W-1:0]  ram_read,
  output logic [1:0]         tile_type,
  output logic [1:0]         rotation,
  output logic [2:0]         xofs,
  output logic [2:0]         yofs,
  input  logic               query_req,
  input  logic [CELL_W-1:0]  query_x,
  input  logic [CELL_W-1:0]  query_y,
  output logic               query_ack,
  output logic [BYTE_W-1:0]  query_data
);

  logic              clear_c;
  logic              line_pre_c, cell_pre_c, render_pre_c, swap_c;
  logic [CELL_W-1:0] next_row_c, next_col_c;
  logic [ADDR_W-1:0] render_addr_c, ram_addr_d, ram_addr_q, q_addr_c;
  logic              q_want_c;
  logic              issue_q, lat_q, nvalid_q;
  tile_attr_t        next_tile_q, cur_tile_q;

  assign clear_c = reset | ~enable;

  // The address register is loaded one cycle ahead so ram_addr carries the
  // fetch address during the issue cycle itself. Fetches beyond the 32-cell
  // map (hpos >= 512) are suppressed so they cannot overwrite the line fetch.
  always_comb begin
    line_pre_c   = (hpos == COORD_W'(LINE_FETCH_H - 1));
    cell_pre_c   = !hpos[9] && (hpos[PHASE_W-1:0] == PHASE_W'(FETCH_PHASE - 1));
    render_pre_c = line_pre_c | cell_pre_c;
    next_row_c   = CELL_W'((vpos + COORD_W'(1)) >> 4);
    next_col_c   = CELL_W'(hpos[8:4] + CELL_W'(1));
    swap_c       = (hpos[PHASE_W-1:0] == PHASE_W'(15));
    if (line_pre_c) render_addr_c = ADDR_W'({next_row_c, CELL_W'(0)});
    else            render_addr_c = ADDR_W'({vpos[8:4], next_col_c});
  end

  always_comb begin
    ram_addr_d = ram_addr_q;
    if (render_pre_c)  ram_addr_d = render_addr_c;
    else if (q_want_c) ram_addr_d = q_addr_c;
  end

  always_ff @(posedge clk) begin
    if (clear_c) begin
      ram_addr_q  <= '0;
      issue_q     <= 1'b0;
      lat_q       <= 1'b0;
      nvalid_q    <= 1'b0;
      next_tile_q <= '0;
      cur_tile_q  <= '0;
    end else begin
      ram_addr_q <= ram_addr_d;
      issue_q    <= render_pre_c;
      lat_q      <= issue_q;
      if (lat_q) begin
        next_tile_q <= cell_attr(ram_read[3:0]);
        nvalid_q    <= 1'b1;
      end
      if (swap_c && nvalid_q) cur_tile_q <= next_tile_q;
    end
  end

  tile_query_fsm #(
    .FETCH_PHASE  (FETCH_PHASE),
    .LINE_FETCH_H (LINE_FETCH_H),
    .ADDR_W       (ADDR_W)
  ) u_query (
    .clk_i        (clk),
    .clear_i      (clear_c),
    .hpos_i       (hpos),
    .req_i        (query_req),
    .x_i          (query_x),
    .y_i          (query_y),
    .ram_read_i   (ram_read),
    .want_bus_c_o (q_want_c),
    .addr_c_o     (q_addr_c),
    .ack_o        (query_ack),
    .data_o       (query_data)
  );

  assign ram_addr  = ram_addr_q;
  assign tile_type = cur_tile_q.ttype;
  assign rotation  = cur_tile_q.rot;
  assign xofs      = hpos[3:1];
  assign yofs      = vpos[3:1];

endmodule
